// File: rtl/bespoke_pkg.sv
// ============================================================================
// Module      : bespoke_pkg
// Description : Shared types and helpers for the vec_argmax classification
//               stage. Optional macro ARGMAX_TIE_LAST_EN makes ties pick the
//               highest index instead of the lowest.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bespoke_pkg;

  typedef logic signed [7:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } argmax_state_t;

  // Width helper that never returns zero, so degenerate sizes still get a 1-bit bus.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Single place for the replace-on-compare rule, shared by chunk and global scans.
  function automatic logic takes_over(input elem_t cand, input elem_t cur);
`ifdef ARGMAX_TIE_LAST_EN
    return cand >= cur;
`else
    return cand > cur;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_argmax_chunk_max.sv
// ============================================================================
// Module      : chunk_max
// Description : Combinational max/offset over one WorkingRegs-byte chunk.
//               Tie rule follows ARGMAX_TIE_LAST_EN through the package helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module chunk_max
  import bespoke_pkg::*;
#(
  parameter  int WorkingRegs = 1,
  localparam int OffWidth    = clog2_min1(WorkingRegs)
) (
  input  logic [WorkingRegs-1:0][7:0] data,
  output elem_t                       max_val,
  output logic [OffWidth-1:0]         max_off
);

  always_comb begin
    max_val = elem_t'(data[0]);
    max_off = '0;
    for (int j = 1; j < WorkingRegs; j++) begin
      if (takes_over(elem_t'(data[j]), max_val)) begin
        max_val = elem_t'(data[j]);
        max_off = OffWidth'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_argmax.sv
// ============================================================================
// Module      : vec_argmax
// Description : Drains one int8 vector from the upstream FIFO chunk by chunk
//               and reports the index/value of its maximum element.
//               Optional macro ARGMAX_TIE_LAST_EN: ties report highest index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vec_argmax
  import bespoke_pkg::*;
#(
  parameter  int InVecLength = 4,
  parameter  int WorkingRegs = 1,
  localparam int IdxWidth    = clog2_min1(InVecLength),
  localparam int NumChunks   = InVecLength / WorkingRegs
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        in_data_ready,
  input  logic [WorkingRegs-1:0][7:0] in_data,
  output logic                        req_chunk_in,
  output logic [IdxWidth-1:0]         out_index,
  output logic [7:0]                  out_max,
  output logic                        out_valid,
  output logic                        busy
);

  localparam int CntWidth = clog2_min1(NumChunks);
  localparam int OffWidth = clog2_min1(WorkingRegs);
  localparam logic [CntWidth-1:0] LastChunk = CntWidth'(NumChunks - 1);

  if (InVecLength < 1 || WorkingRegs < 1) begin : g_size_check
    $error("vec_argmax: InVecLength and WorkingRegs must be >= 1");
  end

  if (InVecLength % WorkingRegs != 0) begin : g_div_check
    $error("vec_argmax: WorkingRegs must divide InVecLength");
  end

  argmax_state_t       state;
  logic [CntWidth-1:0] req_cnt;
  logic [CntWidth-1:0] samp_cnt;
  logic                sample_en;
  elem_t               run_max;
  logic [IdxWidth-1:0] run_idx;
  elem_t               chunk_val;
  logic [OffWidth-1:0] chunk_off;
  logic [IdxWidth-1:0] chunk_idx;

  chunk_max #(
    .WorkingRegs (WorkingRegs)
  ) u_chunk_max (
    .data    (in_data),
    .max_val (chunk_val),
    .max_off (chunk_off)
  );

  always_comb begin
    chunk_idx = IdxWidth'(int'(samp_cnt) * WorkingRegs + int'(chunk_off));
  end

  // FIFO data lags the request by one cycle, so sampling follows a delayed copy of req.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_en <= 1'b0;
      samp_cnt  <= '0;
      run_max   <= '0;
      run_idx   <= '0;
    end else begin
      sample_en <= req_chunk_in;
      if (sample_en) begin
        if (samp_cnt == LastChunk) begin
          samp_cnt <= '0;
        end else begin
          samp_cnt <= samp_cnt + CntWidth'(1);
        end
        if (samp_cnt == '0 || takes_over(chunk_val, run_max)) begin
          run_max <= chunk_val;
          run_idx <= chunk_idx;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      req_cnt      <= '0;
      req_chunk_in <= 1'b0;
      out_index    <= '0;
      out_max      <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_data_ready) begin
            state        <= READ;
            req_cnt      <= '0;
            req_chunk_in <= 1'b1;
            out_valid    <= 1'b0;
            busy         <= 1'b1;
          end
        end
        READ: begin
          if (req_cnt == LastChunk) begin
            req_cnt      <= '0;
            req_chunk_in <= 1'b0;
            state        <= DRAIN;
          end else begin
            req_cnt <= req_cnt + CntWidth'(1);
          end
        end
        DRAIN: begin
          // Publish only once the final chunk has been folded into the running max.
          if (!sample_en) begin
            state     <= DONE;
            out_index <= run_idx;
            out_max   <= run_max;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_argmax.sv
// ============================================================================
// Module      : tb_vec_argmax
// Description : Self-checking bench for vec_argmax with WorkingRegs=1 and 2
//               instances, a FIFO model per instance and a vector-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vec_argmax;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rdy   [2];
  logic       req   [2];
  logic       valid [2];
  logic       busy  [2];
  logic [1:0] idx   [2];
  logic [7:0] mx    [2];

  logic [0:0][7:0] d1;
  logic [1:0][7:0] d2;
  logic [7:0]      q0[$];
  logic [7:0]      q1[$];

  int compared   = 0;
  int mismatched = 0;

  int vec  [4];
  int vec2 [4];
  int ea, ma, eb, mb, reqs, nres;
  logic prev;

  vec_argmax #(.InVecLength(4), .WorkingRegs(1)) u_dut1 (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_data_ready (rdy[0]),
    .in_data       (d1),
    .req_chunk_in  (req[0]),
    .out_index     (idx[0]),
    .out_max       (mx[0]),
    .out_valid     (valid[0]),
    .busy          (busy[0])
  );

  vec_argmax #(.InVecLength(4), .WorkingRegs(2)) u_dut2 (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_data_ready (rdy[1]),
    .in_data       (d2),
    .req_chunk_in  (req[1]),
    .out_index     (idx[1]),
    .out_max       (mx[1]),
    .out_valid     (valid[1]),
    .busy          (busy[1])
  );

  // Upstream FIFO: one-cycle read latency, cleared by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      d1 <= '0;
      d2 <= '0;
    end else begin
      if (req[0]) d1[0] <= (q0.size() > 0) ? q0.pop_front() : 8'h00;
      if (req[1]) begin
        d2[0] <= (q1.size() > 0) ? q1.pop_front() : 8'h00;
        d2[1] <= (q1.size() > 0) ? q1.pop_front() : 8'h00;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: find the maximum value, then pick the first (or last) position holding it.
  function automatic void model(input int v[4], output int ei, output int em);
    em = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > em) em = v[i];
    ei = -1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARGMAX_TIE_LAST_EN
      if (v[i] == em) ei = i;
`else
      if (v[i] == em && ei < 0) ei = i;
`endif
    end
  endfunction

  task automatic push_vec(input int sel, input int v[4]);
    for (int i = 0; i < 4; i++) begin
      if (sel == 0) q0.push_back(8'(v[i]));
      else          q1.push_back(8'(v[i]));
    end
  endtask

  task automatic run_vec(input int sel, input int v[4], input bit toggle);
    int n, r, lat, ei, em;
    n = (sel == 0) ? 4 : 2;
    push_vec(sel, v);
    model(v, ei, em);
    @(negedge clk);
    rdy[sel] = 1'b1;
    @(posedge clk); #1;
    rdy[sel] = 1'b0;
    r   = 0;
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      if (req[sel]) r++;
      if (valid[sel]) lat = j;
      else begin
        if (toggle && j >= 1 && j < n - 1) rdy[sel] = 1'($urandom_range(0, 1));
        else rdy[sel] = 1'b0;
        @(posedge clk); #1;
      end
    end
    check($sformatf("s%0d req_cycles", sel), r, n);
    check($sformatf("s%0d valid_latency", sel), lat, n + 2);
    check($sformatf("s%0d index", sel), int'(idx[sel]), ei);
    check($sformatf("s%0d max", sel), int'($signed(mx[sel])), em);
  endtask

  initial begin
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("s%0d reset req", s), int'(req[s]), 0);
      check($sformatf("s%0d reset valid", s), int'(valid[s]), 0);
      check($sformatf("s%0d reset busy", s), int'(busy[s]), 0);
      check($sformatf("s%0d reset index", s), int'(idx[s]), 0);
      check($sformatf("s%0d reset max", s), int'(mx[s]), 0);
    end
    rst = 1'b0;

    vec = '{0, 0, 0, 1};        run_vec(0, vec, 1'b0);
    vec = '{-5, -3, -1, 1};     run_vec(1, vec, 1'b0);
    vec = '{-11, -9, -7, -5};   run_vec(1, vec, 1'b0);
    vec = '{0, 0, 0, 0};        run_vec(0, vec, 1'b0);
    vec = '{0, 0, 0, 0};        run_vec(1, vec, 1'b0);
    vec = '{7, 127, -128, 127}; run_vec(0, vec, 1'b1);
    vec = '{7, 127, -128, 127}; run_vec(1, vec, 1'b0);

    // Back-to-back vectors with in_data_ready held high.
    vec  = '{1, 2, 3, 4};
    vec2 = '{9, 0, 0, 0};
    model(vec, ea, ma);
    model(vec2, eb, mb);
    push_vec(0, vec);
    push_vec(0, vec2);
    @(negedge clk);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    reqs = 0;
    nres = 0;
    prev = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (req[0]) reqs++;
      if (valid[0] && !prev) begin
        nres++;
        if (nres == 1) begin
          check("b2b first index", int'(idx[0]), ea);
          check("b2b first max", int'($signed(mx[0])), ma);
        end else begin
          check("b2b second index", int'(idx[0]), eb);
          check("b2b second max", int'($signed(mx[0])), mb);
          rdy[0] = 1'b0;
        end
      end
      prev = valid[0];
      @(posedge clk); #1;
    end
    rdy[0] = 1'b0;
    check("b2b req_cycles", reqs, 8);
    check("b2b results", nres, 2);

    // Reset during the second request of a four-chunk run.
    vec = '{5, 6, 7, 8};
    push_vec(0, vec);
    @(negedge clk);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset req", int'(req[0]), 1);
    rst = 1'b1;
    #1;
    check("mid-reset req", int'(req[0]), 0);
    check("mid-reset busy", int'(busy[0]), 0);
    check("mid-reset valid", int'(valid[0]), 0);
    check("mid-reset index", int'(idx[0]), 0);
    check("mid-reset max", int'(mx[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    vec = '{2, 8, 3, 1};
    run_vec(0, vec, 1'b0);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (r % 3 == 0) vec[i] = int'($urandom_range(0, 2)) - 1;
        else            vec[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_vec(r % 2, vec, (r % 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
